// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU: operand width and opcode encoding.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
// Optional feature macro used by the ALU files: ALU_OVERFLOW_EN.
package alu_pkg;

    // Datapath width; the shift amount is fixed at 5 bits, so only 32 is meaningful.
    localparam int WIDTH  = 32;
    localparam int SHAMT_W = 5;

    // Operation select driven by the ALU control decoder.
    // Codes 4'b1100..4'b1111 are unused and produce a zero result.
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SRL  = 4'b0100,
        ALU_SRA  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_XOR  = 4'b1001,
        ALU_NOR  = 4'b1010,
        ALU_LUI  = 4'b1011
    } alu_op_e;

    // Two's-complement overflow from the operand and result sign bits.
    // ADD overflows when both operands share a sign the result does not.
    // SUB overflows when the operands differ in sign and the result's sign
    // differs from the minuend's.
    function automatic logic add_sub_ovf(input logic a_sign,
                                         input logic b_sign,
                                         input logic r_sign,
                                         input logic is_sub);
        logic ovf;
        if (is_sub) begin
            ovf = (a_sign != b_sign) && (r_sign != a_sign);
        end else begin
            ovf = (a_sign == b_sign) && (r_sign != a_sign);
        end
        return ovf;
    endfunction

endpackage

// File: rtl/alu_reg_if.sv
// Operand/control request and registered result bundle between EX-stage control and the ALU.
// Latency: n/a (wiring only).
// Backpressure: none; the ALU accepts every in_valid cycle. `overflow` exists only with ALU_OVERFLOW_EN.
interface alu_reg_if;
    import alu_pkg::*;

    // Request side
    logic                in_valid;
    logic [3:0]          aluCnt;
    logic [WIDTH-1:0]    input1;
    logic [WIDTH-1:0]    input2;
    logic [SHAMT_W-1:0]  shamt;

    // Registered response side
    logic [WIDTH-1:0]    result;
    logic                zero;
    logic                out_valid;
`ifdef ALU_OVERFLOW_EN
    logic                overflow;
`endif

`ifdef ALU_OVERFLOW_EN
    // Pipeline control: drives operands, observes the registered result.
    modport master (
        output in_valid, aluCnt, input1, input2, shamt,
        input  result, zero, out_valid, overflow
    );

    // ALU: consumes operands, drives the registered result.
    modport slave (
        input  in_valid, aluCnt, input1, input2, shamt,
        output result, zero, out_valid, overflow
    );
`else
    // Pipeline control: drives operands, observes the registered result.
    modport master (
        output in_valid, aluCnt, input1, input2, shamt,
        input  result, zero, out_valid
    );

    // ALU: consumes operands, drives the registered result.
    modport slave (
        input  in_valid, aluCnt, input1, input2, shamt,
        output result, zero, out_valid
    );
`endif

endinterface

// File: rtl/alu_comb.sv
// Pure combinational ALU operation mux producing the next result (and overflow with ALU_OVERFLOW_EN).
// Latency: 0 cycles (combinational).
// Backpressure: none; outputs follow the inputs every cycle.
module alu_comb
    import alu_pkg::*;
(
    input  logic [3:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [WIDTH-1:0]   result_o
`ifdef ALU_OVERFLOW_EN
    ,
    output logic               overflow_o
`endif
);

    logic [WIDTH-1:0]        sum;
    logic [WIDTH-1:0]        diff;
    logic signed [WIDTH-1:0] b_s;
    logic                    lt_signed;
    logic                    lt_unsigned;

    // Add/sub wrap modulo 2^WIDTH; carries are deliberately discarded.
    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    assign b_s  = $signed(b_i);

    // Compares use real magnitude comparators rather than the sign of A-B,
    // so SLT stays correct when the subtraction would overflow.
    assign lt_signed   = ($signed(a_i) < $signed(b_i));
    assign lt_unsigned = (a_i < b_i);

    // Operation select; unused codes fall through to a zero result.
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_ADD:  result_o = sum;
            ALU_SLL:  result_o = b_i << shamt_i;
            ALU_SRL:  result_o = b_i >> shamt_i;
            ALU_SRA:  result_o = b_s >>> shamt_i;
            ALU_SUB:  result_o = diff;
            ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, lt_signed};
            ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, lt_unsigned};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_LUI:  result_o = {b_i[15:0], 16'h0000};
            default:  result_o = '0;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    // Signed overflow is only meaningful for ADD and SUB; every other op reports 0.
    always_comb begin
        overflow_o = 1'b0;
        case (op_i)
            ALU_ADD: overflow_o = add_sub_ovf(a_i[WIDTH-1], b_i[WIDTH-1], sum[WIDTH-1], 1'b0);
            ALU_SUB: overflow_o = add_sub_ovf(a_i[WIDTH-1], b_i[WIDTH-1], diff[WIDTH-1], 1'b1);
            default: overflow_o = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_reg.sv
// EX-stage 32-bit ALU with registered result, zero flag, valid (and overflow with ALU_OVERFLOW_EN).
// Latency: 1 cycle; operands sampled with in_valid=1 appear on result/zero at that same edge.
// Backpressure: none; in_valid=0 holds result/zero/overflow and drops out_valid for that cycle.
module alu_reg
    import alu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    alu_reg_if.slave bus
);

    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_d;
    logic             zero_q;
    logic             out_valid_q;
`ifdef ALU_OVERFLOW_EN
    logic             overflow_d;
    logic             overflow_q;
`endif

    alu_comb u_alu_comb (
        .op_i       (bus.aluCnt),
        .a_i        (bus.input1),
        .b_i        (bus.input2),
        .shamt_i    (bus.shamt),
        .result_o   (result_d)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow_o (overflow_d)
`endif
    );

    // Zero flag comes from the combinational result so it lands in the same edge.
    assign zero_d = (result_d == '0);

    // Result/zero capture on valid cycles only; out_valid is a straight delayed copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q <= result_d;
                zero_q   <= zero_d;
            end
        end
    end

`ifdef ALU_OVERFLOW_EN
    // Overflow flag follows the same capture rule as the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (bus.in_valid) begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;
`endif

    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_reg.sv
// Self-checking bench for alu_reg: directed vector table, reset/hold sequences, randomized model check.
// Latency: checks outputs 1 ns after each rising edge.
// Backpressure: n/a; the bench drives in_valid freely. Overflow checks build only with ALU_OVERFLOW_EN.
module tb_alu_reg;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    alu_reg_if bus();

    alu_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z;
        logic        ovf;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Drive one request at the falling edge, then sample just after the next rising edge.
    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        @(negedge clk);
        bus.in_valid = v;
        bus.aluCnt   = op;
        bus.input1   = a;
        bus.input2   = b;
        bus.shamt    = sh;
        @(posedge clk);
        #1;
    endtask

    // Reference model in plain 64-bit integer arithmetic. Returns {overflow, result}.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        longint sa, sb, ua, ub, full;
        logic [31:0] r;
        logic        o;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r  = 32'd0;
        o  = 1'b0;
        full = 0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin full = sa + sb; r = full[31:0]; o = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
            4'd3:  begin full = ub * (longint'(1) << sh); r = full[31:0]; end
            4'd4:  begin full = ub / (longint'(1) << sh); r = full[31:0]; end
            4'd5:  begin full = sb >>> sh; r = full[31:0]; end
            4'd6:  begin full = sa - sb; r = full[31:0]; o = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  r = (ua < ub) ? 32'd1 : 32'd0;
            4'd9:  r = a ^ b;
            4'd10: r = ~(a | b);
            4'd11: begin full = longint'({32'b0, 16'h0, b[15:0]}) * 65536; r = full[31:0]; end
            default: r = 32'd0;
        endcase
        return {o, r};
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    logic [31:0] exp_res;
    logic        exp_z;
    logic        exp_ovf;
    logic [32:0] m;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.aluCnt   = 4'd0;
        bus.input1   = 32'd0;
        bus.input2   = 32'd0;
        bus.shamt    = 5'd0;

        vecs[0]  = '{4'h0, 32'd6,          32'd3,          5'd0,  32'd2,          1'b0, 1'b0};
        vecs[1]  = '{4'h1, 32'd10,         32'd4,          5'd0,  32'd14,         1'b0, 1'b0};
        vecs[2]  = '{4'h3, 32'd4,          32'd12,         5'd2,  32'd48,         1'b0, 1'b0};
        vecs[3]  = '{4'h5, 32'd0,          32'hF000_0000,  5'd4,  32'hFF00_0000,  1'b0, 1'b0};
        vecs[4]  = '{4'h0, 32'd0,          32'd0,          5'd0,  32'd0,          1'b1, 1'b0};
        vecs[5]  = '{4'h6, 32'd5,          32'd5,          5'd0,  32'd0,          1'b1, 1'b0};
        vecs[6]  = '{4'hF, 32'd123,        32'd456,        5'd3,  32'd0,          1'b1, 1'b0};
        vecs[7]  = '{4'h7, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd1,          1'b0, 1'b0};
        vecs[8]  = '{4'h8, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b1, 1'b0};
        vecs[9]  = '{4'h7, 32'h8000_0000,  32'h7FFF_FFFF,  5'd0,  32'd1,          1'b0, 1'b0};
        vecs[10] = '{4'h7, 32'h7FFF_FFFF,  32'h8000_0000,  5'd0,  32'd0,          1'b1, 1'b0};
        vecs[11] = '{4'h4, 32'd0,          32'h8000_0000,  5'd31, 32'd1,          1'b0, 1'b0};
        vecs[12] = '{4'h3, 32'd0,          32'd1,          5'd31, 32'h8000_0000,  1'b0, 1'b0};
        vecs[13] = '{4'h3, 32'd0,          32'hDEAD_BEEF,  5'd0,  32'hDEAD_BEEF,  1'b0, 1'b0};
        vecs[14] = '{4'h5, 32'd0,          32'h8000_0000,  5'd31, 32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[15] = '{4'h2, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b1, 1'b0};
        vecs[16] = '{4'h6, 32'd0,          32'd1,          5'd0,  32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[17] = '{4'h9, 32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0,  32'h0FF0_0FF0,  1'b0, 1'b0};
        vecs[18] = '{4'hA, 32'd0,          32'd0,          5'd0,  32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[19] = '{4'hB, 32'd0,          32'h1234_ABCD,  5'd0,  32'hABCD_0000,  1'b0, 1'b0};
        vecs[20] = '{4'h2, 32'h7FFF_FFFF,  32'd1,          5'd0,  32'h8000_0000,  1'b0, 1'b1};
        vecs[21] = '{4'h6, 32'h8000_0000,  32'd1,          5'd0,  32'h7FFF_FFFF,  1'b0, 1'b1};

        // Reset state, sampled before any clock edge.
        #3;
        chk("reset_result", bus.result, 32'd0);
        chk("reset_zero", {31'd0, bus.zero}, 32'd1);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
`ifdef ALU_OVERFLOW_EN
        chk("reset_overflow", {31'd0, bus.overflow}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Directed table, in_valid=1 on consecutive edges.
        for (int i = 0; i < NVEC; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
            chk($sformatf("vec%0d_result", i), bus.result, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), {31'd0, bus.zero}, {31'd0, vecs[i].z});
            chk($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid}, 32'd1);
`ifdef ALU_OVERFLOW_EN
            chk($sformatf("vec%0d_overflow", i), {31'd0, bus.overflow}, {31'd0, vecs[i].ovf});
`endif
        end

        // Hold: in_valid=0 with different inputs leaves the last result in place.
        drive(1'b0, 4'h2, 32'd111, 32'd222, 5'd0);
        chk("hold_result", bus.result, 32'h7FFF_FFFF);
        chk("hold_zero", {31'd0, bus.zero}, 32'd0);
        chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd0);
`ifdef ALU_OVERFLOW_EN
        chk("hold_overflow", {31'd0, bus.overflow}, 32'd1);
`endif

        // Mid-cycle asynchronous reset while a valid stream is running.
        drive(1'b1, 4'h1, 32'h0000_F000, 32'h0000_000F, 5'd0);
        chk("prereset_result", bus.result, 32'h0000_F00F);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_result", bus.result, 32'd0);
        chk("async_rst_zero", {31'd0, bus.zero}, 32'd1);
        chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // First edge after deassertion with in_valid=1 gives valid output.
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.aluCnt   = 4'h2;
        bus.input1   = 32'd2;
        bus.input2   = 32'd3;
        @(posedge clk);
        #1;
        chk("post_rst_result", bus.result, 32'd5);
        chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
        exp_res = 32'd5;
        exp_z   = 1'b0;
        exp_ovf = 1'b0;

        // Randomized traffic against the model; the model holds state across invalid cycles.
        for (int i = 0; i < 400; i++) begin
            logic        v;
            logic [3:0]  op;
            logic [31:0] a, b;
            logic [4:0]  sh;
            v  = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 15));
            a  = pick_operand();
            b  = pick_operand();
            sh = 5'($urandom_range(0, 31));
            drive(v, op, a, b, sh);
            if (v) begin
                m       = ref_alu(op, a, b, sh);
                exp_res = m[31:0];
                exp_z   = (m[31:0] == 32'd0);
                exp_ovf = m[32];
            end
            chk($sformatf("rnd%0d_op%0h_result", i, op), bus.result, exp_res);
            chk($sformatf("rnd%0d_zero", i), {31'd0, bus.zero}, {31'd0, exp_z});
            chk($sformatf("rnd%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, v});
`ifdef ALU_OVERFLOW_EN
            chk($sformatf("rnd%0d_overflow", i), {31'd0, bus.overflow}, {31'd0, exp_ovf});
`endif
        end

        @(negedge clk);
        bus.in_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_reg.md
Name: alu_reg

Overview:
- 32-bit integer ALU with a registered result and zero flag, one cycle of latency.
- Sits in the datapath EX stage. Driven by a 4-bit control code from the ALU control decoder, two 32-bit operands, and a 5-bit shift amount.
- Produces a result word plus a zero flag, used for branch compare.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; shamt stays 5 bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/control valid this cycle
- aluCnt  in  4  operation select
- input1  in  32  operand A (rs)
- input2  in  32  operand B (rt/immediate); the shifted operand for shifts
- shamt  in  5  shift amount for shift ops
- result  out  32  registered result
- zero  out  1  registered; 1 when result == 0
- out_valid  out  1  registered copy of in_valid

Behaviour:
- One clock, one asynchronous active-high reset. rst=1 forces result=0, zero=1, out_valid=0 immediately, independent of clk.
- Latency 1: inputs sampled on a rising clk edge with in_valid=1 appear on result/zero at that edge, with out_valid=1.
- in_valid=0 at an edge: result and zero hold their previous values; out_valid=0. There is no backpressure.
- Opcodes (aluCnt), with A=input1 and B=input2:
  - 0000 AND: A & B
  - 0001 OR: A | B
  - 0010 ADD: A + B, mod 2^32
  - 0011 SLL: B << shamt
  - 0100 SRL: B >> shamt, logical
  - 0101 SRA: B >>> shamt, sign-filled
  - 0110 SUB: A - B, mod 2^32
  - 0111 SLT: signed A < B gives 1, else 0
  - 1000 SLTU: unsigned A < B gives 1, else 0
  - 1001 XOR: A ^ B
  - 1010 NOR: ~(A | B)
  - 1011 LUI: {B[15:0], 16'h0}
  - 1100–1111: result 0 (zero=1)
- zero is computed from the combinational result and registered in the same edge as result.
- Add/sub wrap silently; no exception is raised.
- Shift by 0 passes B unchanged. Shift by 31 is the maximum; shamt has no bits above [4:0].
- SLT must use true signed comparison, not the sign of A-B, so it is correct across overflow. Example: 0x80000000 < 0x7FFFFFFF gives 1.
- Reset deasserted mid-stream: the first edge after deassertion with in_valid=1 produces valid output.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- When defined, adds output port `overflow` (1 bit, registered, reset 0). It is set for ADD when A and B share a sign that differs from the result's sign. It is set for SUB when A and B differ in sign and the result's sign differs from A's. It is 0 for all other ops. It holds its value when in_valid=0.
- When undefined, the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - 4-bit opcode localparams (ALU_AND … ALU_LUI) as an enum typedef
  - WIDTH constant
- Natural sub-module alu_comb: pure combinational op mux producing next result (and overflow).
- alu_reg wraps alu_comb with the output registers and reset.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> result=0, zero=1, out_valid=0 immediately.
- AND then OR, in_valid=1 on consecutive edges:
  - aluCnt=0000, A=6, B=3 -> result=2, zero=0 one cycle later
  - next edge, aluCnt=0001, A=10, B=4 -> result=14
- SLL: aluCnt=0011, A=4, B=12, shamt=2 -> result=48. SRA: B=0xF0000000, shamt=4 -> 0xFF000000.
- Zero flag:
  - AND with A=0, B=0 -> result=0, zero=1
  - SUB with A=5, B=5 -> result=0, zero=1
  - opcode 1111 -> result=0, zero=1
- Compares:
  - SLT, A=0xFFFFFFFF, B=1 -> 1
  - SLTU, same operands -> 0
  - SLT, A=0x80000000, B=0x7FFFFFFF -> 1
- Hold/overflow:
  - in_valid=0 with changed inputs -> result unchanged, out_valid=0
  - with ALU_OVERFLOW_EN, ADD A=0x7FFFFFFF, B=1 -> result=0x80000000, overflow=1
